// File: rtl/axi_ar_route_tracker.sv
// ---------------------------------------------------------------------------
// axi_ar_route_tracker
//
// Read-address router and in-flight tracker for one AXI initiator.
// Each AR request is decoded against per-port address regions and offered
// to exactly one destination AR allocator. Outstanding reads are counted.
// A new read is held back whenever it would target a different port than
// the reads still in flight, so R data can only ever come back in order
// from a single port. A read is also held back when the tracker is full.
//
// Optional feature macro: AXI_AR_DECERR_EN
//   defined   : an address that matches no enabled region is accepted
//               locally (no port request, no tracking). decerr_o pulses
//               for one cycle afterwards, with the offending address on
//               decerr_addr_o.
//   undefined : an unmatched address is routed to port N_MASTER_PORT-1
//               and tracked like any other read. The decerr ports are absent.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   araddr_i, arvalid_i : initiator AR address / valid
//   arready_o           : initiator AR ready (combinational pass of grant)
//   START_ADDR_i        : per-port region base, inclusive (packed, port 0 in LSBs)
//   END_ADDR_i          : per-port region end, inclusive (packed, port 0 in LSBs)
//   enable_region_i     : per-port region enable
//   arvalid_o           : one-hot request towards each port's AR allocator
//   arready_i           : per-port grant from the AR allocators
//   rvalid_i, rready_i,
//   rlast_i             : R channel handshake; the last beat retires a read
//   outstanding_o       : current in-flight read count
//   decerr_o,
//   decerr_addr_o       : decode-error pulse and address (AXI_AR_DECERR_EN only)
// ---------------------------------------------------------------------------
module axi_ar_route_tracker #(
  parameter int AXI_ADDRESS_W   = 32,
  parameter int N_MASTER_PORT   = 4,
  parameter int MAX_OUTSTANDING = 8,
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1),
  localparam int DEST_W = (N_MASTER_PORT > 1) ? $clog2(N_MASTER_PORT) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [AXI_ADDRESS_W-1:0]               araddr_i,
  input  logic                                   arvalid_i,
  output logic                                   arready_o,
  input  logic [N_MASTER_PORT*AXI_ADDRESS_W-1:0] START_ADDR_i,
  input  logic [N_MASTER_PORT*AXI_ADDRESS_W-1:0] END_ADDR_i,
  input  logic [N_MASTER_PORT-1:0]               enable_region_i,
  output logic [N_MASTER_PORT-1:0]               arvalid_o,
  input  logic [N_MASTER_PORT-1:0]               arready_i,
  input  logic                                   rvalid_i,
  input  logic                                   rready_i,
  input  logic                                   rlast_i,
`ifdef AXI_AR_DECERR_EN
  output logic                                   decerr_o,
  output logic [AXI_ADDRESS_W-1:0]               decerr_addr_o,
`endif
  output logic [CNT_W-1:0]                       outstanding_o
);

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic [N_MASTER_PORT-1:0] region_hit;
  logic [DEST_W-1:0]        match_idx;
  logic                     matched;

  // NOTE: every variable assigned in an always_comb gets a default first,
  // so no path through the block can leave it holding an old value (latch).
  always_comb begin
    region_hit = '0;
    for (int k = 0; k < N_MASTER_PORT; k++) begin
      region_hit[k] = enable_region_i[k]
                   && (araddr_i >= START_ADDR_i[k*AXI_ADDRESS_W +: AXI_ADDRESS_W])
                   && (araddr_i <= END_ADDR_i[k*AXI_ADDRESS_W +: AXI_ADDRESS_W]);
    end
  end

  // Walk from the top down so the lowest matching index is written last.
  always_comb begin
    match_idx = '0;
    matched   = 1'b0;
    for (int k = N_MASTER_PORT - 1; k >= 0; k--) begin
      if (region_hit[k]) begin
        match_idx = DEST_W'(k);
        matched   = 1'b1;
      end
    end
  end

  // dest   : port this request would be sent to
  // routed : request goes to a port (as opposed to a local decode error)
  logic [DEST_W-1:0] dest;
  logic              routed;

`ifdef AXI_AR_DECERR_EN
  assign dest   = match_idx;
  assign routed = matched;
`else
  assign dest   = matched ? match_idx : DEST_W'(N_MASTER_PORT - 1);
  assign routed = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // Tracking state
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]  cnt;
  logic [DEST_W-1:0] last_dest;

  logic cnt_full;
  logic dest_conflict;
  logic stall;

  assign cnt_full      = (cnt == CNT_W'(MAX_OUTSTANDING));
  // last_dest is only meaningful while reads are in flight.
  assign dest_conflict = (cnt != '0) && (dest != last_dest);
  assign stall         = cnt_full || dest_conflict;

  // -------------------------------------------------------------------------
  // AR request / ready steering
  // -------------------------------------------------------------------------
  always_comb begin
    arvalid_o = '0;
    arready_o = 1'b0;
    if (routed) begin
      if (!stall) begin
        arvalid_o[dest] = arvalid_i;
        arready_o       = arready_i[dest];
      end
    end else begin
      // Unmatched with decode errors enabled: absorb the request locally.
      arready_o = 1'b1;
    end
  end

  logic ar_hs;
  logic route_hs;
  logic r_last_hs;

  assign ar_hs     = arvalid_i && arready_o;
  assign route_hs  = ar_hs && routed;
  // A retiring beat at cnt==0 belongs to nothing we track (e.g. after reset).
  assign r_last_hs = rvalid_i && rready_i && rlast_i && (cnt != '0);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      last_dest <= '0;
    end else begin
      case ({route_hs, r_last_hs})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (route_hs) begin
        last_dest <= dest;
      end
    end
  end

  assign outstanding_o = cnt;

  // -------------------------------------------------------------------------
  // Decode-error report
  // -------------------------------------------------------------------------
`ifdef AXI_AR_DECERR_EN
  logic decerr_hs;

  assign decerr_hs = ar_hs && !routed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decerr_o      <= 1'b0;
      decerr_addr_o <= '0;
    end else begin
      decerr_o <= decerr_hs;
      if (decerr_hs) begin
        decerr_addr_o <= araddr_i;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_ar_route_tracker.sv
// ---------------------------------------------------------------------------
// tb_axi_ar_route_tracker
//
// Directed bench for axi_ar_route_tracker with default parameters
// (32-bit address, 4 ports, 8 outstanding). Inputs change 1 ns after the
// rising edge; outputs are observed 1 ns later, well before the next edge.
//
// Region map used throughout:
//   port 0 : 0x0000-0x0FFF enabled
//   port 1 : 0x1000-0x1FFF enabled
//   port 2 : 0x0000-0x2FFF enabled (overlaps port 0; port 0 must win)
//   port 3 : 0x4000-0x4FFF disabled
// ---------------------------------------------------------------------------
module tb_axi_ar_route_tracker;

  localparam int AW = 32;
  localparam int NP = 4;
  localparam int MO = 8;
  localparam int CW = $clog2(MO + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic [AW-1:0]  araddr_i;
  logic           arvalid_i;
  logic           arready_o;
  logic [NP*AW-1:0] START_ADDR_i;
  logic [NP*AW-1:0] END_ADDR_i;
  logic [NP-1:0]  enable_region_i;
  logic [NP-1:0]  arvalid_o;
  logic [NP-1:0]  arready_i;
  logic           rvalid_i;
  logic           rready_i;
  logic           rlast_i;
  logic [CW-1:0]  outstanding_o;
`ifdef AXI_AR_DECERR_EN
  logic           decerr_o;
  logic [AW-1:0]  decerr_addr_o;
`endif

  axi_ar_route_tracker #(
    .AXI_ADDRESS_W  (AW),
    .N_MASTER_PORT  (NP),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .araddr_i       (araddr_i),
    .arvalid_i      (arvalid_i),
    .arready_o      (arready_o),
    .START_ADDR_i   (START_ADDR_i),
    .END_ADDR_i     (END_ADDR_i),
    .enable_region_i(enable_region_i),
    .arvalid_o      (arvalid_o),
    .arready_i      (arready_i),
    .rvalid_i       (rvalid_i),
    .rready_i       (rready_i),
    .rlast_i        (rlast_i),
`ifdef AXI_AR_DECERR_EN
    .decerr_o       (decerr_o),
    .decerr_addr_o  (decerr_addr_o),
`endif
    .outstanding_o  (outstanding_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ar(input logic [AW-1:0] addr, input logic v, input logic [NP-1:0] rdy);
    araddr_i  = addr;
    arvalid_i = v;
    arready_i = rdy;
  endtask

  task automatic set_r(input logic b);
    rvalid_i = b;
    rready_i = b;
    rlast_i  = b;
  endtask

  initial begin
    rst             = 1'b1;
    set_ar('0, 1'b0, '0);
    set_r(1'b0);
    START_ADDR_i    = {32'h0000_4000, 32'h0000_0000, 32'h0000_1000, 32'h0000_0000};
    END_ADDR_i      = {32'h0000_4FFF, 32'h0000_2FFF, 32'h0000_1FFF, 32'h0000_0FFF};
    enable_region_i = 4'b0111;

    // ---------------- reset state ----------------
    #1;
    check("rst_cnt",     64'(outstanding_o), 64'd0);
    check("rst_arvalid", 64'(arvalid_o),     64'd0);
    check("rst_arready", 64'(arready_o),     64'd0);
    cycle();
    cycle();
    rst = 1'b0;

    // ---------------- decode at cnt==0, no grant ----------------
    set_ar(32'h0000_0FFF, 1'b1, 4'b0000); #1;
    check("dec_0fff_top_of_r0",  64'(arvalid_o), 64'b0001);
    check("dec_no_grant_ready",  64'(arready_o), 64'd0);
    set_ar(32'h0000_1000, 1'b1, 4'b0000); #1;
    check("dec_1000_base_of_r1", 64'(arvalid_o), 64'b0010);
    set_ar(32'h0000_0008, 1'b1, 4'b0000); #1;
    check("dec_overlap_lowest",  64'(arvalid_o), 64'b0001);
    set_ar(32'h0000_2004, 1'b1, 4'b0000); #1;
    check("dec_2004_r2",         64'(arvalid_o), 64'b0100);
    set_ar(32'h0000_1004, 1'b0, 4'b1111); #1;
    check("dec_no_valid",        64'(arvalid_o), 64'b0000);
    cycle();
    check("no_hs_cnt",           64'(outstanding_o), 64'd0);

    // ---------------- single accept to port 1 ----------------
    set_ar(32'h0000_1004, 1'b1, 4'b0010); #1;
    check("acc1_arvalid", 64'(arvalid_o), 64'b0010);
    check("acc1_arready", 64'(arready_o), 64'd1);
    cycle();
    check("acc1_cnt",     64'(outstanding_o), 64'd1);

    // ---------------- conflict stall, release on rlast ----------------
    set_ar(32'h0000_0008, 1'b1, 4'b1111); #1;
    check("conf_arvalid", 64'(arvalid_o), 64'd0);
    check("conf_arready", 64'(arready_o), 64'd0);
    set_r(1'b1);
    cycle();
    set_r(1'b0); #1;
    check("conf_cnt_drained", 64'(outstanding_o), 64'd0);
    check("conf_rel_arvalid", 64'(arvalid_o),     64'b0001);
    check("conf_rel_arready", 64'(arready_o),     64'd1);
    cycle();
    check("conf_acc_cnt",     64'(outstanding_o), 64'd1);
    arvalid_i = 1'b0;
    set_r(1'b1);
    cycle();
    set_r(1'b0);
    check("conf_back_to_0",   64'(outstanding_o), 64'd0);

    // ---------------- fill to MAX, 9th stalls ----------------
    set_ar(32'h0000_0008, 1'b1, 4'b1111);
    repeat (8) cycle();
    check("full_cnt",     64'(outstanding_o), 64'd8);
    check("full_arvalid", 64'(arvalid_o),     64'd0);
    check("full_arready", 64'(arready_o),     64'd0);
    set_r(1'b1);
    cycle();
    set_r(1'b0); #1;
    check("full_cnt_7",   64'(outstanding_o), 64'd7);
    check("full_rel_rdy", 64'(arready_o),     64'd1);
    cycle();
    check("full_refill",  64'(outstanding_o), 64'd8);
    arvalid_i = 1'b0;

    // ---------------- simultaneous inc/dec, underflow ----------------
    set_r(1'b1);
    repeat (5) cycle();
    set_r(1'b0);
    check("drain_to_3", 64'(outstanding_o), 64'd3);
    set_ar(32'h0000_0008, 1'b1, 4'b1111);
    set_r(1'b1); #1;
    check("both_arready", 64'(arready_o), 64'd1);
    cycle();
    arvalid_i = 1'b0;
    check("both_cnt_3", 64'(outstanding_o), 64'd3);
    repeat (3) cycle();
    check("drain_to_0", 64'(outstanding_o), 64'd0);
    cycle();
    set_r(1'b0);
    check("underflow_0", 64'(outstanding_o), 64'd0);

    // ---------------- unmatched address ----------------
    set_ar(32'h0000_8000, 1'b1, 4'b0000); #1;
`ifdef AXI_AR_DECERR_EN
    check("unm_arvalid", 64'(arvalid_o), 64'd0);
    check("unm_arready", 64'(arready_o), 64'd1);
    cycle();
    arvalid_i = 1'b0;
    check("unm_decerr",  64'(decerr_o),      64'd1);
    check("unm_addr",    64'(decerr_addr_o), 64'h8000);
    check("unm_cnt",     64'(outstanding_o), 64'd0);
    cycle();
    check("unm_decerr_pulse", 64'(decerr_o), 64'd0);
`else
    check("unm_arvalid",    64'(arvalid_o), 64'b1000);
    check("unm_arready_0",  64'(arready_o), 64'd0);
    arready_i = 4'b1000; #1;
    check("unm_arready_1",  64'(arready_o), 64'd1);
    cycle();
    check("unm_cnt",        64'(outstanding_o), 64'd1);
    set_ar(32'h0000_1004, 1'b1, 4'b1111); #1;
    check("unm_conf_stall", 64'(arvalid_o), 64'd0);
    arvalid_i = 1'b0;
    set_r(1'b1);
    cycle();
    set_r(1'b0);
    check("unm_drained",    64'(outstanding_o), 64'd0);
`endif

    // ---------------- asynchronous reset mid-burst ----------------
    set_ar(32'h0000_1004, 1'b1, 4'b0010);
    repeat (5) cycle();
    arvalid_i = 1'b0;
    check("pre_rst_cnt",  64'(outstanding_o), 64'd5);
    check("pre_rst_dest", 64'(dut.last_dest), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_cnt",  64'(outstanding_o), 64'd0);
    check("async_rst_dest", 64'(dut.last_dest), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle();
    set_r(1'b1);
    cycle();
    set_r(1'b0);
    check("post_rst_rlast_ignored", 64'(outstanding_o), 64'd0);
    set_ar(32'h0000_2004, 1'b1, 4'b0100); #1;
    check("post_rst_accept", 64'(arready_o), 64'd1);
    cycle();
    arvalid_i = 1'b0;
    check("post_rst_cnt",    64'(outstanding_o), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
